expr_parser: RTL and testbench
==============================

EXPR_PARSER -- requirements
Module: expr_parser

Interface
REQ-001 SHALL provide parameter MAX_DEPTH, default 4, maximum parenthesis nesting depth (1..15).
REQ-002 SHALL provide parameter MAX_DIGITS, default 3, maximum digits per number literal (1..15).
REQ-003 SHALL provide parameter ALLOW_SPACE, default 1: 1 = space (0x20) is a separator; 0 = space is an illegal character.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  qualifies `in` for one character per cycle.
REQ-007 in  input  8  ASCII character.
REQ-008 out  output  1  high while the characters accepted so far form a complete, balanced, legal expression.
REQ-009 err  output  1  sticky high once an illegal sequence is seen.
REQ-010 depth  output  4  current open-parenthesis count.

Function
REQ-011 Character classes: digit 0x30-0x39; operator '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F; open '(' 0x28; close ')' 0x29; space 0x20; all other codes are illegal.
REQ-012 SHALL implement a four-state FSM: EXPECT (operand required), NUM (inside number), CLOSE (operand complete, operator or ')' required), ERR (sticky).
REQ-013 SHALL keep a digit counter dcnt (4 bits) and a depth counter (4 bits).
REQ-014 When in_valid=0, state, dcnt and depth SHALL hold.
REQ-015 EXPECT: digit -> NUM, dcnt=1; '(' with depth<MAX_DEPTH -> depth+1, stay EXPECT; '(' with depth==MAX_DEPTH -> ERR; space (ALLOW_SPACE=1) -> no change; anything else -> ERR.
REQ-016 NUM: digit with dcnt<MAX_DIGITS -> dcnt+1; digit with dcnt==MAX_DIGITS -> ERR; operator -> EXPECT; ')' with depth>0 -> depth-1, CLOSE; ')' with depth==0 -> ERR; space (ALLOW_SPACE=1) -> CLOSE; anything else -> ERR.
REQ-017 CLOSE: operator -> EXPECT; ')' with depth>0 -> depth-1, stay CLOSE; ')' with depth==0 -> ERR; space (ALLOW_SPACE=1) -> no change; anything else (digit, '(') -> ERR.
REQ-018 ERR: SHALL remain in ERR, ignoring all input, until clr; depth and dcnt freeze at their pre-error values.
REQ-019 err SHALL equal (state==ERR).
REQ-020 out SHALL equal (state==NUM or state==CLOSE) and depth==0 and state!=ERR, decoded from registers only.
REQ-021 Latency: out/err/depth SHALL reflect an accepted character in the cycle after the edge that samples it (one-cycle latency).
REQ-022 Empty input (no characters since reset) SHALL give out=0, err=0.
REQ-023 A trailing operator or unmatched '(' SHALL give out=0 without setting err (expression incomplete, not illegal).
REQ-024 Depth counter SHALL never wrap: increment only below MAX_DEPTH, decrement only above 0; otherwise ERR.
REQ-025 Leading zeros SHALL be legal and count toward MAX_DIGITS.

Reset
REQ-026 On clr=1 at a rising edge: state=EXPECT, dcnt=0, depth=0; hence out=0, err=0, depth=0 from the next cycle.
REQ-027 clr SHALL take priority over in_valid in the same cycle; the character presented is discarded.
REQ-028 clr SHALL clear ERR and recover from any state, including mid-number and mid-nesting.

Verification
REQ-029 clr, then "12+3" on consecutive cycles -> out after each char 1,1,0,1; err=0 throughout.
REQ-030 "(1+2)*3" -> depth 1 after '(', out=0 until ')', out=1 and depth=0 after ')', 0 after '*', 1 after '3'.
REQ-031 MAX_DEPTH=4, "(((((" -> depth 1,2,3,4 then err=1 on 5th, depth holds 4, out=0; further "1" ignored.
REQ-032 MAX_DIGITS=3, "123" -> out=1; next '4' -> err=1, out=0; "1)" from reset -> err=1 at ')'.
REQ-033 ALLOW_SPACE=1: "1 + 2" -> out=1 at end; "1 2" -> err=1 at '2'; ALLOW_SPACE=0: "1 " -> err=1.
REQ-034 "5+" with in_valid gaps between chars -> outputs hold during gaps, final out=0, err=0; then clr asserted together with in_valid=1,'7' -> next cycle out=0, err=0, depth=0.

Source files
------------

// File: rtl/expr_parser.sv
// expr_parser: streaming syntax checker for simple arithmetic expressions.
// Accepts one ASCII character per valid cycle and tracks whether the text
// seen so far forms a complete, balanced, legal expression. Numbers are
// bounded in length, parentheses are bounded in nesting, and any illegal
// sequence latches a sticky error until the next clear.
module expr_parser #(
   parameter int MAX_DEPTH   = 4,
   parameter int MAX_DIGITS  = 3,
   parameter int ALLOW_SPACE = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       in_valid,
   input  logic [7:0] in,
   output logic       out,
   output logic       err,
   output logic [3:0] depth
);

   typedef enum logic [1:0] {
      EXPECT = 2'd0,
      NUM    = 2'd1,
      CLOSE  = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam logic [3:0] maxDepth  = 4'(MAX_DEPTH);
   localparam logic [3:0] maxDigits = 4'(MAX_DIGITS);
   localparam bit         spaceOk   = (ALLOW_SPACE != 0);

   state_t     state;
   logic [3:0] dcnt;

   logic isDigit;
   logic isOp;
   logic isOpen;
   logic isClose;
   logic isSpace;

   // Classify the incoming character; space only counts as a separator when enabled.
   always_comb begin
      isDigit = (in >= 8'h30) && (in <= 8'h39);
      isOp    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
      isOpen  = (in == 8'h28);
      isClose = (in == 8'h29);
      isSpace = spaceOk && (in == 8'h20);
   end

   // Parser FSM with digit and nesting counters; counters freeze once in ERR.
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= EXPECT;
         dcnt  <= 4'd0;
         depth <= 4'd0;
      end else if (in_valid) begin
         case (state)
            EXPECT: begin
               if (isDigit) begin
                  state <= NUM;
                  dcnt  <= 4'd1;
               end else if (isOpen) begin
                  if (depth < maxDepth) depth <= depth + 4'd1;
                  else                  state <= ERR;
               end else if (!isSpace) begin
                  state <= ERR;
               end
            end
            NUM: begin
               if (isDigit) begin
                  if (dcnt < maxDigits) dcnt  <= dcnt + 4'd1;
                  else                  state <= ERR;
               end else if (isOp) begin
                  state <= EXPECT;
               end else if (isClose) begin
                  if (depth != 4'd0) begin
                     depth <= depth - 4'd1;
                     state <= CLOSE;
                  end else begin
                     state <= ERR;
                  end
               end else if (isSpace) begin
                  state <= CLOSE;
               end else begin
                  state <= ERR;
               end
            end
            CLOSE: begin
               if (isOp) begin
                  state <= EXPECT;
               end else if (isClose) begin
                  if (depth != 4'd0) depth <= depth - 4'd1;
                  else               state <= ERR;
               end else if (!isSpace) begin
                  state <= ERR;
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= ERR;
            end
         endcase
      end
   end

   // Status outputs decoded purely from the state and depth registers.
   always_comb begin
      err = (state == ERR);
      out = ((state == NUM) || (state == CLOSE)) && (depth == 4'd0);
   end

endmodule

// File: tb/tb_expr_parser.sv
// tb_expr_parser: directed checks of expr_parser with hand-computed
// expectations. A second instance built with spaces disallowed covers the
// illegal-space case; both instances share the same stimulus.
module tb_expr_parser;

   logic       clk;
   logic       clr;
   logic       in_valid;
   logic [7:0] in;

   logic       out,   err;
   logic [3:0] depth;
   logic       outNs, errNs;
   logic [3:0] depthNs;

   int  passCount;
   int  checkCount;
   bit  useNs;

   expr_parser #(.MAX_DEPTH(4), .MAX_DIGITS(3), .ALLOW_SPACE(1)) dut (
      .clk      (clk),
      .clr      (clr),
      .in_valid (in_valid),
      .in       (in),
      .out      (out),
      .err      (err),
      .depth    (depth)
   );

   expr_parser #(.MAX_DEPTH(4), .MAX_DIGITS(3), .ALLOW_SPACE(0)) dutNs (
      .clk      (clk),
      .clr      (clr),
      .in_valid (in_valid),
      .in       (in),
      .out      (outNs),
      .err      (errNs),
      .depth    (depthNs)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of input, then sample #1 after the edge that consumed it.
   task automatic applyStimulus(input logic [7:0] c, input logic v, input logic r);
      in       = c;
      in_valid = v;
      clr      = r;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr      = 1'b0;
      in       = 8'h00;
   endtask

   // Compare the selected instance's outputs against the expected triple.
   task automatic checkOutput(input string tag, input logic expOut,
                              input logic expErr, input logic [3:0] expDepth);
      logic       obsOut;
      logic       obsErr;
      logic [3:0] obsDepth;
      obsOut   = useNs ? outNs   : out;
      obsErr   = useNs ? errNs   : err;
      obsDepth = useNs ? depthNs : depth;
      checkCount++;
      assert (obsOut === expOut) passCount++;
      else $error("[TB] FAIL %s out: observed %b expected %b", tag, obsOut, expOut);
      checkCount++;
      assert (obsErr === expErr) passCount++;
      else $error("[TB] FAIL %s err: observed %b expected %b", tag, obsErr, expErr);
      checkCount++;
      assert (obsDepth === expDepth) passCount++;
      else $error("[TB] FAIL %s depth: observed %0d expected %0d", tag, obsDepth, expDepth);
   endtask

   task automatic step(input string tag, input logic [7:0] c,
                       input logic expOut, input logic expErr, input logic [3:0] expDepth);
      applyStimulus(c, 1'b1, 1'b0);
      checkOutput(tag, expOut, expErr, expDepth);
   endtask

   task automatic gap(input string tag, input logic expOut,
                      input logic expErr, input logic [3:0] expDepth);
      applyStimulus("x", 1'b0, 1'b0);
      checkOutput(tag, expOut, expErr, expDepth);
   endtask

   task automatic doClear();
      applyStimulus(8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      useNs      = 1'b0;
      clr        = 1'b1;
      in_valid   = 1'b0;
      in         = 8'h00;
      @(posedge clk);
      #1;
      doClear();
      checkOutput("reset", 1'b0, 1'b0, 4'd0);

      // "12+3"
      step("12+3 c1", "1", 1'b1, 1'b0, 4'd0);
      step("12+3 c2", "2", 1'b1, 1'b0, 4'd0);
      step("12+3 c3", "+", 1'b0, 1'b0, 4'd0);
      step("12+3 c4", "3", 1'b1, 1'b0, 4'd0);

      // "(1+2)*3"
      doClear();
      step("paren (", "(", 1'b0, 1'b0, 4'd1);
      step("paren 1", "1", 1'b0, 1'b0, 4'd1);
      step("paren +", "+", 1'b0, 1'b0, 4'd1);
      step("paren 2", "2", 1'b0, 1'b0, 4'd1);
      step("paren )", ")", 1'b1, 1'b0, 4'd0);
      step("paren *", "*", 1'b0, 1'b0, 4'd0);
      step("paren 3", "3", 1'b1, 1'b0, 4'd0);

      // Nesting limit
      doClear();
      step("nest 1", "(", 1'b0, 1'b0, 4'd1);
      step("nest 2", "(", 1'b0, 1'b0, 4'd2);
      step("nest 3", "(", 1'b0, 1'b0, 4'd3);
      step("nest 4", "(", 1'b0, 1'b0, 4'd4);
      step("nest 5", "(", 1'b0, 1'b1, 4'd4);
      step("nest ignored", "1", 1'b0, 1'b1, 4'd4);

      // Nested close back to zero
      doClear();
      step("dbl (", "(", 1'b0, 1'b0, 4'd1);
      step("dbl ((", "(", 1'b0, 1'b0, 4'd2);
      step("dbl 9", "9", 1'b0, 1'b0, 4'd2);
      step("dbl )", ")", 1'b0, 1'b0, 4'd1);
      step("dbl ))", ")", 1'b1, 1'b0, 4'd0);
      step("dbl )))", ")", 1'b0, 1'b1, 4'd0);

      // Digit limit, and counter restart for the next number
      doClear();
      step("dig 1", "1", 1'b1, 1'b0, 4'd0);
      step("dig 2", "2", 1'b1, 1'b0, 4'd0);
      step("dig 3", "3", 1'b1, 1'b0, 4'd0);
      step("dig /", "/", 1'b0, 1'b0, 4'd0);
      step("dig 0", "0", 1'b1, 1'b0, 4'd0);
      step("dig 00", "0", 1'b1, 1'b0, 4'd0);
      step("dig 007", "7", 1'b1, 1'b0, 4'd0);
      step("dig 4th", "4", 1'b0, 1'b1, 4'd0);

      // Unmatched close
      doClear();
      step("1) 1", "1", 1'b1, 1'b0, 4'd0);
      step("1) )", ")", 1'b0, 1'b1, 4'd0);

      // Spaces as separators
      doClear();
      step("sp 1", "1", 1'b1, 1'b0, 4'd0);
      step("sp sp1", " ", 1'b1, 1'b0, 4'd0);
      step("sp +", "+", 1'b0, 1'b0, 4'd0);
      step("sp sp2", " ", 1'b0, 1'b0, 4'd0);
      step("sp 2", "2", 1'b1, 1'b0, 4'd0);

      doClear();
      step("1 2 a", "1", 1'b1, 1'b0, 4'd0);
      step("1 2 b", " ", 1'b1, 1'b0, 4'd0);
      step("1 2 c", "2", 1'b0, 1'b1, 4'd0);

      // Illegal character
      doClear();
      step("illegal a", "a", 1'b0, 1'b1, 4'd0);

      // Space disallowed instance
      doClear();
      useNs = 1'b1;
      step("nospace 1", "1", 1'b1, 1'b0, 4'd0);
      step("nospace sp", " ", 1'b0, 1'b1, 4'd0);
      useNs = 1'b0;

      // Gaps in in_valid, then clear colliding with a valid character
      doClear();
      step("gap 5", "5", 1'b1, 1'b0, 4'd0);
      gap("gap hold1", 1'b1, 1'b0, 4'd0);
      gap("gap hold2", 1'b1, 1'b0, 4'd0);
      step("gap +", "+", 1'b0, 1'b0, 4'd0);
      gap("gap hold3", 1'b0, 1'b0, 4'd0);
      applyStimulus("7", 1'b1, 1'b1);
      checkOutput("clr priority", 1'b0, 1'b0, 4'd0);
      step("after clr +", "+", 1'b0, 1'b1, 4'd0);

      // Recovery from mid-nesting via clear
      doClear();
      step("rec (", "(", 1'b0, 1'b0, 4'd1);
      doClear();
      checkOutput("rec clr", 1'b0, 1'b0, 4'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
